// File: rtl/reg_write_demux_8.sv
// Write-side bank of eight W-bit registers: valid/ready write port, 2-edge commit
// pipeline with one-hot strobe, and a drain-then-clear engine. Optional macro REG0_ZERO_EN.
module reg_write_demux_8 #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_sel,
  input  logic [W-1:0]     wr_data,
  input  logic             clr_start,
  output logic             clr_busy,
  output logic [7:0]       wr_en_onehot,
  output logic [8*W-1:0]   reg_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     clr_idx_q, clr_idx_d;
  logic           stage_valid_q, stage_valid_d;
  logic [2:0]     stage_sel_q, stage_sel_d;
  logic [W-1:0]   stage_data_q, stage_data_d;
  logic [7:0]     wr_en_onehot_q, wr_en_onehot_d;
  logic [W-1:0]   regs_q [8];
  logic [W-1:0]   regs_d [8];

  function automatic logic [7:0] onehot8(input logic [2:0] sel);
    logic [7:0] oh;
    case (sel)
      3'd0:    oh = 8'b0000_0001;
      3'd1:    oh = 8'b0000_0010;
      3'd2:    oh = 8'b0000_0100;
      3'd3:    oh = 8'b0000_1000;
      3'd4:    oh = 8'b0001_0000;
      3'd5:    oh = 8'b0010_0000;
      3'd6:    oh = 8'b0100_0000;
      3'd7:    oh = 8'b1000_0000;
      default: oh = 8'b0000_0000;
    endcase
    return oh;
  endfunction

  assign wr_ready     = (state_q == ST_IDLE);
  assign clr_busy     = (state_q != ST_IDLE);
  assign wr_en_onehot = wr_en_onehot_q;

  // Next-state, staging, commit and clear logic
  always_comb begin
    state_d        = state_q;
    clr_idx_d      = clr_idx_q;
    stage_valid_d  = 1'b0;
    stage_sel_d    = stage_sel_q;
    stage_data_d   = stage_data_q;
    wr_en_onehot_d = 8'b0000_0000;
    regs_d         = regs_q;

    // A staged write always commits, including in the DRAIN cycle
    if (stage_valid_q) begin
      regs_d[stage_sel_q] = stage_data_q;
      wr_en_onehot_d      = onehot8(stage_sel_q);
    end else begin
      wr_en_onehot_d = 8'b0000_0000;
    end

    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_DRAIN;
        end else if (wr_valid) begin
          stage_valid_d = 1'b1;
          stage_sel_d   = wr_sel;
          stage_data_d  = wr_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        state_d   = ST_CLEAR;
        clr_idx_d = 3'd0;
      end
      ST_CLEAR: begin
        regs_d[clr_idx_q] = {W{1'b0}};
        clr_idx_d         = clr_idx_q + 3'd1;
        if (clr_idx_q == 3'd7) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_idx_d = 3'd0;
      end
    endcase

`ifdef REG0_ZERO_EN
    regs_d[0] = {W{1'b0}};
`else
    regs_d[0] = regs_d[0];
`endif
  end

  // State, pipeline stage, strobe and register bank flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      clr_idx_q      <= 3'd0;
      stage_valid_q  <= 1'b0;
      stage_sel_q    <= 3'd0;
      stage_data_q   <= {W{1'b0}};
      wr_en_onehot_q <= 8'b0000_0000;
      for (int k = 0; k < 8; k++) begin
        regs_q[k] <= {W{1'b0}};
      end
    end else begin
      state_q        <= state_d;
      clr_idx_q      <= clr_idx_d;
      stage_valid_q  <= stage_valid_d;
      stage_sel_q    <= stage_sel_d;
      stage_data_q   <= stage_data_d;
      wr_en_onehot_q <= wr_en_onehot_d;
      for (int k = 0; k < 8; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_out
    assign reg_out[g*W +: W] = regs_q[g];
  end

endmodule

// File: doc/reg_write_demux_8.md
Name: reg_write_demux_8

Overview:
- Write-side counterpart of the 8:1 read select path.
- Accepts write transactions over a valid/ready handshake and decodes a 3-bit select into a one-hot write enable. Holds eight W-bit registers and exposes all of them in parallel so the existing 8:1 read mux can select them.
- Includes a sequenced clear engine that zeroes the bank one register per cycle.

Parameters:
W, 8, data width of each register.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  reset, asynchronous, active-low.
wr_valid  input  1  write request valid.
wr_ready  output  1  block can accept a write this cycle.
wr_sel  input  3  target register index 0..7.
wr_data  input  W  write data.
clr_start  input  1  request to clear all registers; sampled only in IDLE.
clr_busy  output  1  clear sequence in progress (DRAIN or CLEAR).
wr_en_onehot  output  8  registered one-hot strobe of the register committed on the previous edge.
reg_out  output  8*W  register contents; reg k occupies bits [k*W +: W].

Behaviour:
- Reset (rst_n low, takes effect immediately without a clock):
  - All registers = 0.
  - Pipeline stage invalid.
  - wr_en_onehot = 0, clr_busy = 0.
  - State = IDLE, clear index = 0.
  - wr_ready = 1 once in IDLE.
  - A pending staged write is discarded.
- Handshake:
  - A write is accepted at an edge where wr_valid && wr_ready.
  - wr_ready = 1 only in IDLE and is combinational from state.
  - wr_sel/wr_data may change freely while wr_valid is low.
- Pipeline:
  - Edge N (accept): stage captures sel/data and stage_valid = 1.
  - Edge N+1 (commit): reg[sel] = data, and wr_en_onehot = 1<<sel during the following cycle.
  - reg_out shows the new value after edge N+1, so latency is 2 edges.
  - Back-to-back accepts are allowed, giving 1 write/cycle throughput.
  - Consecutive writes to the same index: the last one wins.
  - Unwritten registers hold their value.
- The one-hot decode is a pure function of the staged sel; exactly one bit is set on a commit, otherwise all 0.
- FSM (states IDLE, DRAIN, CLEAR):
  - IDLE -> DRAIN when clr_start = 1 at an edge.
    - clr_start has priority over wr_valid in the same cycle; that write is NOT accepted.
  - DRAIN (1 cycle):
    - Any pending stage write commits normally (with its strobe).
    - No new accepts.
    - Always entered, even with nothing pending.
    - Next state CLEAR, idx = 0.
  - CLEAR (8 cycles):
    - At each edge reg[idx] = 0, then idx increments.
    - After clearing idx 7, return to IDLE; idx wraps to 0.
    - wr_en_onehot = 0 throughout CLEAR.
  - clr_busy = 1 in DRAIN and CLEAR: 9 cycles total.
  - clr_start asserted while busy is ignored (not queued).
- Registers not yet reached by the clear keep their prior values until their cycle.

Optional Feature:
- Macro REG0_ZERO_EN.
- When defined:
  - Register 0 is hardwired to 0 and reg_out[W-1:0] is constant 0.
  - Writes with sel = 0 are still accepted and take the normal pipeline slot.
  - They produce wr_en_onehot = 8'b0000_0001 but do not change storage.
- When undefined, register 0 is an ordinary register.

Test Plan:
- Reset: rst_n low mid-stream with a staged write pending -> all reg_out 0, wr_en_onehot 0, clr_busy 0, wr_ready 1 after release; the pending write never appears.
- Single write, sel=5, data=8'hA5 accepted at edge N -> reg_out[47:40] = 8'hA5 after edge N+1, wr_en_onehot = 8'b0010_0000 for one cycle, all other registers unchanged.
- Burst: 8 back-to-back writes sel=0..7, data=8'h10+sel -> one commit per cycle; final reg k = 8'h10+k; wr_ready stays 1.
- Clear: write sel=3, data=8'h3C, then clr_start on the next cycle alongside wr_valid (sel=4, data=8'hFF):
  - reg3 = 8'h3C commits during DRAIN.
  - The sel=4 write is not accepted.
  - clr_busy high for exactly 9 cycles, wr_ready 0 during those cycles.
  - All registers 0 afterwards.
- clr_start pulsed again during CLEAR -> ignored; returns to IDLE exactly 9 cycles after the first start.
- With REG0_ZERO_EN: write sel=0, data=8'hFF -> strobe 8'b0000_0001, reg_out[7:0] remains 0; without the macro it reads 8'hFF.
